// File: rtl/key_schedule_seq.sv
// AES-128 key schedule sequencer: walks an external single-round expansion
// function through rounds 1..10, generating Rcon and chaining round keys, and
// streams round keys 0..10 to the cipher core over a valid/ready handshake.
module key_schedule_seq #(
    parameter int unsigned EXP_LAT = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic [127:0] exp_key,
    output logic [31:0]  exp_rcon,
    input  logic [127:0] exp_rkey,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_data,
    output logic         busy,
    output logic         done
);

    localparam int unsigned KEY_W   = 128;
    localparam int unsigned RCON_W  = 8;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned LAT_W   = (EXP_LAT > 1) ? $clog2(EXP_LAT) : 1;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(10);
    localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(EXP_LAT - 1);
    localparam logic [RCON_W-1:0]  RCON_FIRST = 8'h01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        COMPUTE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [KEY_W-1:0]    cur_key;
    logic [KEY_W-1:0]    cur_key_n;
    logic [RCON_W-1:0]   rcon;
    logic [RCON_W-1:0]   rcon_n;
    logic [RCON_W-1:0]   rcon_out;
    logic [RCON_W-1:0]   rcon_out_n;
    logic [LAT_W-1:0]    lat;
    logic [LAT_W-1:0]    lat_n;
    logic [KEY_W-1:0]    rk_data_n;
    logic [ROUND_W-1:0]  rk_round_n;
    logic                rk_valid_n;
    logic                busy_n;
    logic                done_n;

    // GF(2^8) doubling used to step Rcon from one round to the next
    function automatic logic [RCON_W-1:0] xtime(input logic [RCON_W-1:0] b);
        return {b[RCON_W-2:0], 1'b0} ^ (b[RCON_W-1] ? 8'h1b : 8'h00);
    endfunction

    // cur_key is cleared on return to IDLE, so it can drive exp_key directly
    assign exp_key  = cur_key;
    assign exp_rcon = {rcon_out, 24'h000000};

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_key  <= '0;
            rcon     <= '0;
            rcon_out <= '0;
            lat      <= '0;
            rk_data  <= '0;
            rk_round <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cur_key  <= cur_key_n;
            rcon     <= rcon_n;
            rcon_out <= rcon_out_n;
            lat      <= lat_n;
            rk_data  <= rk_data_n;
            rk_round <= rk_round_n;
            rk_valid <= rk_valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_n    = state;
        cur_key_n  = cur_key;
        rcon_n     = rcon;
        rcon_out_n = rcon_out;
        lat_n      = lat;
        rk_data_n  = rk_data;
        rk_round_n = rk_round;
        rk_valid_n = rk_valid;
        busy_n     = busy;
        done_n     = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n    = EMIT;
                    cur_key_n  = key;
                    rk_data_n  = key;
                    rk_round_n = '0;
                    rcon_n     = RCON_FIRST;
                    rk_valid_n = 1'b1;
                    busy_n     = 1'b1;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    rk_valid_n = 1'b0;
                    if (rk_round == LAST_ROUND) begin
                        state_n   = IDLE;
                        cur_key_n = '0;
                        busy_n    = 1'b0;
                        done_n    = 1'b1;
                    end else begin
                        state_n    = COMPUTE;
                        lat_n      = '0;
                        rcon_out_n = rcon;
                    end
                end
            end
            COMPUTE: begin
                if (lat == LAT_LAST) begin
                    state_n    = EMIT;
                    cur_key_n  = exp_rkey;
                    rk_data_n  = exp_rkey;
                    rk_round_n = rk_round + ROUND_W'(1);
                    rcon_n     = xtime(rcon);
                    rcon_out_n = '0;
                    rk_valid_n = 1'b1;
                end else begin
                    lat_n = lat + LAT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
